ppm_frame_ctrl: RTL and testbench

//  Parametrised frame controller behind the PPM symbol decoder: gates decoded bytes between SOF and EOF.

---
 rtl/ppm_pkg.sv | 20 ++
 rtl/ppm_timeout_cnt.sv | 51 +++++
 rtl/ppm_frame_ctrl.sv | 177 +++++++++++++++++
 tb/tb_ppm_frame_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppm_pkg.sv
// ---------------------------------------------------------------------------
// ppm_pkg
// Shared types and constants for the PPM frame controller.
//   state_e  : frame controller states (idle, receiving, one-cycle done)
//   ERR_*    : err_code values reported on the err_code output
// ---------------------------------------------------------------------------
package ppm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [1:0] ERR_NONE   = 2'b00;
   localparam logic [1:0] ERR_RESYNC = 2'b01;
   localparam logic [1:0] ERR_OVFL   = 2'b10;
   localparam logic [1:0] ERR_TMO    = 2'b11;

endpackage : ppm_pkg

// File: rtl/ppm_timeout_cnt.sv
// ---------------------------------------------------------------------------
// ppm_timeout_cnt
// Inactivity timer. Counts ticks since the last clear and raises a
// combinational expiry pulse on the TIMEOUT-th consecutive tick.
// Ports:
//   clk16     in  clock (posedge)
//   rst_n     in  asynchronous active-low reset
//   clear_i   in  restart the count from zero (wins over tick_i)
//   tick_i    in  one idle cycle elapsed
//   expired_o out high in the cycle whose tick completes TIMEOUT idle cycles
// ---------------------------------------------------------------------------
module ppm_timeout_cnt
   import ppm_pkg::*;
#(
   parameter int TIMEOUT = 4096
) (
   input  logic clk16,
   input  logic rst_n,
   input  logic clear_i,
   input  logic tick_i,
   output logic expired_o
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // The counter holds TIMEOUT-1 after TIMEOUT-1 idle ticks, so the next
   // tick is the TIMEOUT-th one and fires the expiry.
   assign expired_o = tick_i && !clear_i && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || expired_o) begin
         cnt_d = '0;
      end else if (tick_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk16 or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : ppm_timeout_cnt

// File: rtl/ppm_frame_ctrl.sv
// ---------------------------------------------------------------------------
// ppm_frame_ctrl
// Frame controller behind the PPM symbol decoder. Passes decoded bytes to
// the downstream sink only between SOF and EOF, counts bytes per frame,
// flags overflow, inactivity timeout and unexpected SOF (resync), and
// reports frame completion.
// Ports:
//   clk16        in  16x oversample clock
//   rst_n        in  asynchronous active-low reset
//   sof_rcv_in   in  start-of-frame pulse
//   eof_rcv_in   in  end-of-frame pulse
//   onebyte_in   in  dout_data holds a complete byte
//   dout_data    in  decoded byte
//   Dout         out last accepted byte (held)
//   dout_valid   out Dout updated this cycle
//   frame_active out receiving a frame
//   byte_cnt     out bytes accepted in current frame
//   frame_done   out pulse at good EOF, frame_len valid
//   frame_len    out byte count of last completed frame (held)
//   frame_err    out pulse on any error
//   err_code     out last error cause, cleared by SOF from idle
// ---------------------------------------------------------------------------
module ppm_frame_ctrl
   import ppm_pkg::*;
#(
   parameter  int DATA_W  = 8,
   parameter  int MAX_LEN = 255,
   parameter  int TIMEOUT = 4096,
   localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic              clk16,
   input  logic              rst_n,
   input  logic              sof_rcv_in,
   input  logic              eof_rcv_in,
   input  logic              onebyte_in,
   input  logic [DATA_W-1:0] dout_data,
   output logic [DATA_W-1:0] Dout,
   output logic              dout_valid,
   output logic              frame_active,
   output logic [LEN_W-1:0]  byte_cnt,
   output logic              frame_done,
   output logic [LEN_W-1:0]  frame_len,
   output logic              frame_err,
   output logic [1:0]        err_code
);

   localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

   state_e            state_q,  state_d;
   logic [DATA_W-1:0] dout_q,   dout_d;
   logic              valid_q,  valid_d;
   logic [LEN_W-1:0]  cnt_q,    cnt_d;
   logic              done_q,   done_d;
   logic [LEN_W-1:0]  len_q,    len_d;
   logic              err_q,    err_d;
   logic [1:0]        code_q,   code_d;

   logic tmr_clear;
   logic tmr_tick;
   logic tmr_expired;
   logic at_max;

   assign at_max = (cnt_q == MAX_CNT);

   ppm_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk16     (clk16),
      .rst_n     (rst_n),
      .clear_i   (tmr_clear),
      .tick_i    (tmr_tick),
      .expired_o (tmr_expired)
   );

   always_comb begin
      state_d   = state_q;
      dout_d    = dout_q;
      valid_d   = 1'b0;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      len_d     = len_q;
      err_d     = 1'b0;
      code_d    = code_q;
      tmr_clear = 1'b1;
      tmr_tick  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // Bytes and EOF outside a frame are dropped; SOF wins over EOF.
            if (sof_rcv_in) begin
               state_d = ST_RECV;
               cnt_d   = '0;
               code_d  = ERR_NONE;
            end
         end

         ST_RECV: begin
            // Any activity restarts the inactivity timer.
            tmr_clear = onebyte_in || eof_rcv_in || sof_rcv_in;
            tmr_tick  = !tmr_clear;

            if (eof_rcv_in) begin
               // A same-cycle byte is taken before closing, unless it
               // would overflow, in which case EOF still wins silently.
               if (onebyte_in && !at_max) begin
                  dout_d  = dout_data;
                  valid_d = 1'b1;
                  cnt_d   = cnt_q + 1'b1;
               end
               len_d   = cnt_d;
               done_d  = 1'b1;
               state_d = ST_DONE;
            end else if (onebyte_in && at_max) begin
               err_d   = 1'b1;
               code_d  = ERR_OVFL;
               state_d = ST_IDLE;
            end else if (sof_rcv_in) begin
               // Restart the frame in place; the same-cycle byte is lost.
               err_d  = 1'b1;
               code_d = ERR_RESYNC;
               cnt_d  = '0;
            end else if (onebyte_in) begin
               dout_d  = dout_data;
               valid_d = 1'b1;
               cnt_d   = cnt_q + 1'b1;
            end else if (tmr_expired) begin
               err_d   = 1'b1;
               code_d  = ERR_TMO;
               state_d = ST_IDLE;
            end
         end

         ST_DONE: begin
            if (sof_rcv_in) begin
               state_d = ST_RECV;
               cnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk16 or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         dout_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         len_q   <= '0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
      end else begin
         state_q <= state_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         len_q   <= len_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   assign Dout         = dout_q;
   assign dout_valid   = valid_q;
   assign frame_active = (state_q == ST_RECV);
   assign byte_cnt     = cnt_q;
   assign frame_done   = done_q;
   assign frame_len    = len_q;
   assign frame_err    = err_q;
   assign err_code     = code_q;

endmodule : ppm_frame_ctrl

// File: tb/tb_ppm_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ppm_frame_ctrl
// Directed scenarios plus a randomized run against a frame-level reference
// model (mode, byte count, idle-cycle count).
// ---------------------------------------------------------------------------
module tb_ppm_frame_ctrl;

   localparam int DATA_W  = 8;
   localparam int MAX_LEN = 4;
   localparam int TIMEOUT = 16;
   localparam int LEN_W   = $clog2(MAX_LEN + 1);

   logic              clk16 = 1'b0;
   logic              rst_n = 1'b0;
   logic              sof = 1'b0;
   logic              eof = 1'b0;
   logic              ob  = 1'b0;
   logic [DATA_W-1:0] din = '0;

   logic [DATA_W-1:0] Dout;
   logic              dout_valid;
   logic              frame_active;
   logic [LEN_W-1:0]  byte_cnt;
   logic              frame_done;
   logic [LEN_W-1:0]  frame_len;
   logic              frame_err;
   logic [1:0]        err_code;

   ppm_frame_ctrl #(
      .DATA_W  (DATA_W),
      .MAX_LEN (MAX_LEN),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk16        (clk16),
      .rst_n        (rst_n),
      .sof_rcv_in   (sof),
      .eof_rcv_in   (eof),
      .onebyte_in   (ob),
      .dout_data    (din),
      .Dout         (Dout),
      .dout_valid   (dout_valid),
      .frame_active (frame_active),
      .byte_cnt     (byte_cnt),
      .frame_done   (frame_done),
      .frame_len    (frame_len),
      .frame_err    (frame_err),
      .err_code     (err_code)
   );

   always #5 clk16 = ~clk16;

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: 0 = outside frame, 1 = in frame, 2 = frame just closed.
   int          m_mode;
   int          m_cnt;
   int          m_idle;
   int          m_len;
   logic [7:0]  m_dout;
   bit          m_valid, m_done, m_err;
   int          m_code;

   task automatic model_reset();
      m_mode = 0; m_cnt = 0; m_idle = 0; m_len = 0; m_dout = '0;
      m_valid = 0; m_done = 0; m_err = 0; m_code = 0;
   endtask

   task automatic model_step(input bit s, input bit e, input bit o, input logic [7:0] d);
      m_valid = 0; m_done = 0; m_err = 0;
      if (m_mode == 0) begin
         if (s) begin m_mode = 1; m_cnt = 0; m_idle = 0; m_code = 0; end
      end else if (m_mode == 1) begin
         if (e) begin
            if (o && m_cnt < MAX_LEN) begin m_dout = d; m_valid = 1; m_cnt++; end
            m_len = m_cnt; m_done = 1; m_mode = 2;
         end else if (o && m_cnt == MAX_LEN) begin
            m_err = 1; m_code = 2; m_mode = 0;
         end else if (s) begin
            m_err = 1; m_code = 1; m_cnt = 0; m_idle = 0;
         end else if (o) begin
            m_dout = d; m_valid = 1; m_cnt++; m_idle = 0;
         end else begin
            m_idle++;
            if (m_idle == TIMEOUT) begin m_err = 1; m_code = 3; m_mode = 0; end
         end
      end else begin
         if (s) begin m_mode = 1; m_cnt = 0; m_idle = 0; end
         else m_mode = 0;
      end
   endtask

   // One clk16 cycle of stimulus; outputs are then stable 1 time unit after the edge.
   task automatic drive(input bit s, input bit e, input bit o, input logic [7:0] d);
      sof = s; eof = e; ob = o; din = d;
      @(posedge clk16);
      model_step(s, e, o, d);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk16);
      #1;
      vectors++; if (Dout !== 8'h00)       begin miscompares++; $display("FAIL reset_dout got %h want 00", Dout); end
      vectors++; if (dout_valid !== 1'b0)  begin miscompares++; $display("FAIL reset_valid got %b want 0", dout_valid); end
      vectors++; if (frame_active !== 1'b0) begin miscompares++; $display("FAIL reset_active got %b want 0", frame_active); end
      vectors++; if (byte_cnt !== 3'd0)    begin miscompares++; $display("FAIL reset_cnt got %0d want 0", byte_cnt); end
      vectors++; if (frame_len !== 3'd0)   begin miscompares++; $display("FAIL reset_len got %0d want 0", frame_len); end
      vectors++; if (frame_done !== 1'b0 || frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_pulses got done=%b err=%b want 0 0", frame_done, frame_err); end
      vectors++; if (err_code !== 2'b00)   begin miscompares++; $display("FAIL reset_code got %b want 00", err_code); end
      rst_n = 1'b1;
      drive(0, 0, 0, 8'h00);
      $display("reset: released, outputs checked");
   endtask

   task automatic test_normal();
      logic [7:0] bytes [3];
      bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF;
      drive(1, 0, 0, 8'h00);
      vectors++; if (frame_active !== 1'b1) begin miscompares++; $display("FAIL normal_active got %b want 1", frame_active); end
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, bytes[i]);
         vectors++;
         if (dout_valid !== 1'b1 || Dout !== bytes[i] || byte_cnt !== 3'(i + 1)) begin
            miscompares++;
            $display("FAIL normal_byte%0d got valid=%b dout=%h cnt=%0d want 1 %h %0d", i, dout_valid, Dout, byte_cnt, bytes[i], i + 1);
         end
      end
      drive(0, 1, 0, 8'h00);
      vectors++;
      if (frame_done !== 1'b1 || frame_len !== 3'd3 || Dout !== 8'hFF || err_code !== 2'b00 || dout_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL normal_eof got done=%b len=%0d dout=%h code=%b valid=%b want 1 3 ff 00 0", frame_done, frame_len, Dout, err_code, dout_valid);
      end
      drive(0, 0, 0, 8'h00);
      vectors++; if (frame_done !== 1'b0 || frame_active !== 1'b0) begin miscompares++; $display("FAIL normal_after got done=%b active=%b want 0 0", frame_done, frame_active); end
      $display("normal: 3-byte frame, frame_len=%0d", frame_len);
   endtask

   task automatic test_overflow();
      drive(1, 0, 0, 8'h00);
      for (int i = 0; i < MAX_LEN; i++) drive(0, 0, 1, 8'(8'h10 + i));
      vectors++; if (byte_cnt !== 3'(MAX_LEN) || frame_err !== 1'b0) begin miscompares++; $display("FAIL ovfl_full got cnt=%0d err=%b want %0d 0", byte_cnt, frame_err, MAX_LEN); end
      drive(0, 0, 1, 8'h99);
      vectors++;
      if (frame_err !== 1'b1 || err_code !== 2'b10 || frame_active !== 1'b0 || Dout !== 8'h13 || dout_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL ovfl_err got err=%b code=%b active=%b dout=%h valid=%b want 1 10 0 13 0", frame_err, err_code, frame_active, Dout, dout_valid);
      end
      drive(0, 0, 0, 8'h00);
      vectors++; if (frame_err !== 1'b0 || err_code !== 2'b10 || byte_cnt !== 3'(MAX_LEN)) begin miscompares++; $display("FAIL ovfl_hold got err=%b code=%b cnt=%0d want 0 10 %0d", frame_err, err_code, byte_cnt, MAX_LEN); end
      $display("overflow: byte %0d rejected, err_code=%b", MAX_LEN + 1, err_code);
   endtask

   task automatic test_timeout();
      drive(1, 0, 0, 8'h00);
      drive(0, 0, 1, 8'h42);
      for (int i = 1; i < TIMEOUT; i++) begin
         drive(0, 0, 0, 8'h00);
         vectors++;
         if (frame_err !== 1'b0 || frame_active !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_early idle=%0d got err=%b active=%b want 0 1", i, frame_err, frame_active);
         end
      end
      drive(0, 0, 0, 8'h00);
      vectors++;
      if (frame_err !== 1'b1 || err_code !== 2'b11 || frame_active !== 1'b0) begin
         miscompares++;
         $display("FAIL tmo_fire got err=%b code=%b active=%b want 1 11 0", frame_err, err_code, frame_active);
      end
      $display("timeout: fired after %0d idle cycles", TIMEOUT);
   endtask

   task automatic test_resync();
      int errs;
      errs = 0;
      drive(1, 0, 0, 8'h00);
      vectors++; if (err_code !== 2'b00) begin miscompares++; $display("FAIL resync_clear got code=%b want 00", err_code); end
      drive(0, 0, 1, 8'h01); drive(0, 0, 1, 8'h02);
      drive(1, 0, 1, 8'hEE);
      errs += int'(frame_err);
      vectors++;
      if (frame_err !== 1'b1 || err_code !== 2'b01 || byte_cnt !== 3'd0 || frame_active !== 1'b1 || Dout !== 8'h02) begin
         miscompares++;
         $display("FAIL resync_err got err=%b code=%b cnt=%0d active=%b dout=%h want 1 01 0 1 02", frame_err, err_code, byte_cnt, frame_active, Dout);
      end
      drive(0, 0, 1, 8'h03); errs += int'(frame_err);
      drive(0, 1, 0, 8'h00); errs += int'(frame_err);
      vectors++; if (frame_done !== 1'b1 || frame_len !== 3'd1) begin miscompares++; $display("FAIL resync_done got done=%b len=%0d want 1 1", frame_done, frame_len); end
      vectors++; if (errs != 1) begin miscompares++; $display("FAIL resync_errcount got %0d want 1", errs); end
      drive(0, 0, 0, 8'h00);
      $display("resync: frame restarted, frame_len=%0d", frame_len);
   endtask

   task automatic test_simultaneous();
      drive(1, 0, 0, 8'h00);
      drive(0, 0, 1, 8'h11);
      drive(0, 1, 1, 8'h77);
      vectors++;
      if (Dout !== 8'h77 || dout_valid !== 1'b1 || frame_done !== 1'b1 || frame_len !== 3'd2) begin
         miscompares++;
         $display("FAIL simul_byte_eof got dout=%h valid=%b done=%b len=%0d want 77 1 1 2", Dout, dout_valid, frame_done, frame_len);
      end
      drive(0, 0, 0, 8'h00);
      drive(1, 1, 0, 8'h00);
      vectors++;
      if (frame_active !== 1'b1 || frame_done !== 1'b0 || byte_cnt !== 3'd0) begin
         miscompares++;
         $display("FAIL simul_idle_sof_eof got active=%b done=%b cnt=%0d want 1 0 0", frame_active, frame_done, byte_cnt);
      end
      drive(1, 1, 0, 8'h00);
      vectors++; if (frame_done !== 1'b1 || frame_err !== 1'b0 || frame_len !== 3'd0) begin miscompares++; $display("FAIL simul_recv_sof_eof got done=%b err=%b len=%0d want 1 0 0", frame_done, frame_err, frame_len); end
      drive(0, 0, 0, 8'h00);
      $display("simultaneous: byte+eof and sof+eof handled");
   endtask

   task automatic test_reset_mid();
      drive(1, 0, 0, 8'h00);
      drive(0, 0, 1, 8'h5A);
      drive(0, 0, 1, 8'h6B);
      rst_n = 1'b0;
      model_reset();
      @(posedge clk16); #1;
      vectors++;
      if (Dout !== 8'h00 || dout_valid !== 1'b0 || frame_active !== 1'b0 || byte_cnt !== 3'd0 ||
          frame_done !== 1'b0 || frame_err !== 1'b0 || frame_len !== 3'd0 || err_code !== 2'b00) begin
         miscompares++;
         $display("FAIL midrst_outputs got dout=%h valid=%b active=%b cnt=%0d done=%b err=%b len=%0d code=%b want all 0",
                  Dout, dout_valid, frame_active, byte_cnt, frame_done, frame_err, frame_len, err_code);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(0, (i == 2), 1, 8'(8'hC0 + i));
         vectors++;
         if (dout_valid !== 1'b0 || byte_cnt !== 3'd0 || Dout !== 8'h00 || frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_ignore%0d got valid=%b cnt=%0d dout=%h done=%b want 0 0 00 0", i, dout_valid, byte_cnt, Dout, frame_done);
         end
      end
      $display("reset_mid: frame aborted, stray bytes ignored");
   endtask

   task automatic test_random();
      int pct_sof, pct_eof, pct_ob;
      int bad;
      for (int ph = 0; ph < 4; ph++) begin
         case (ph)
            0: begin pct_sof = 6;  pct_eof = 6;  pct_ob = 40; end
            1: begin pct_sof = 3;  pct_eof = 2;  pct_ob = 5;  end
            2: begin pct_sof = 10; pct_eof = 10; pct_ob = 60; end
            default: begin pct_sof = 4; pct_eof = 1; pct_ob = 25; end
         endcase
         bad = 0;
         for (int c = 0; c < 300; c++) begin
            drive(($urandom_range(0, 99) < pct_sof), ($urandom_range(0, 99) < pct_eof),
                  ($urandom_range(0, 99) < pct_ob), 8'($urandom));
            vectors++;
            if (Dout !== m_dout || dout_valid !== m_valid || frame_active !== (m_mode == 1) ||
                byte_cnt !== 3'(m_cnt) || frame_done !== m_done || frame_len !== 3'(m_len) ||
                frame_err !== m_err || err_code !== 2'(m_code)) begin
               miscompares++; bad++;
               $display("FAIL rand_ph%0d_c%0d got dout=%h v=%b act=%b cnt=%0d done=%b len=%0d err=%b code=%b want %h %b %b %0d %b %0d %b %0d",
                        ph, c, Dout, dout_valid, frame_active, byte_cnt, frame_done, frame_len, frame_err, err_code,
                        m_dout, m_valid, (m_mode == 1), m_cnt, m_done, m_len, m_err, m_code);
            end
         end
         $display("random: phase %0d, 300 cycles, %0d bad", ph, bad);
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_overflow();
      test_timeout();
      test_resync();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_ppm_frame_ctrl
